lift_controller: RTL and testbench
==================================

LIFT_CONTROLLER -- requirements
Module: lift_controller

Interface
REQ-001 The block SHALL have parameter TRAVEL_CYCLES, default 50_000_000, giving the clock cycles needed to travel one floor.
REQ-002 The block SHALL have parameter DOOR_CYCLES, default 100_000_000, giving the clock cycles the door stays open.
REQ-003 The block SHALL have port iCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port iRST_N, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port chamada, input, 4 bits: floor call buttons, bit i = floor i, level-sampled each cycle.
REQ-006 The block SHALL have port estado_atual, output, 2 bits: 0 = parado, 1 = subindo, 2 = descendo; it feeds the LCD stage directly.
REQ-007 The block SHALL have port lcd_refresh, output, 1 bit: one-cycle pulse that restarts the LCD message sequence.
REQ-008 The block SHALL have port andar_atual, output, 2 bits: current floor, 0..3.
REQ-009 The block SHALL have port pedidos, output, 4 bits: pending request register.
REQ-010 The block SHALL have port porta_aberta, output, 1 bit: door open indicator.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, MOVE_UP, MOVE_DOWN and DOOR_OPEN.
REQ-012 estado_atual SHALL be 1 in MOVE_UP, 2 in MOVE_DOWN, and 0 in IDLE and DOOR_OPEN; the value 3 SHALL never be driven.
REQ-013 porta_aberta SHALL be 1 exactly while the FSM is in DOOR_OPEN.
REQ-014 Each cycle, pedidos SHALL update to (pedidos | chamada) & ~clear_mask; clear_mask is the bit of the floor being served on that edge, so clear beats a same-cycle press on that floor.
REQ-015 In DOOR_OPEN, a press on andar_atual SHALL NOT be latched; it SHALL reset the door counter to 0 instead.
REQ-016 IDLE decisions SHALL use registered pedidos with priority: current floor (go to DOOR_OPEN, clear bit) > any floor above (MOVE_UP, dir=up) > any floor below (MOVE_DOWN, dir=down); with no requests the FSM SHALL stay in IDLE.
REQ-017 A 27-bit counter SHALL be cleared on entry to every state.
REQ-018 In MOVE_x, on the edge where the counter equals TRAVEL_CYCLES-1, andar_atual SHALL step ±1 and the counter SHALL clear.
REQ-019 On that same edge, if the pedidos bit of the new floor is set, the FSM SHALL go to DOOR_OPEN and clear that bit; otherwise it SHALL stay in MOVE_x.
REQ-020 In DOOR_OPEN, on the edge where the counter equals DOOR_CYCLES-1, the next state SHALL be chosen in this order: requests ahead in dir (keep dir) > requests behind (reverse dir) > IDLE.
REQ-021 andar_atual SHALL never step above 3 or below 0; the scheduling rules guarantee this, and a movement with no target SHALL return the FSM to IDLE.
REQ-022 lcd_refresh SHALL be 1 in exactly the first cycle a new estado_atual value is visible, and 0 otherwise; there SHALL be no pulse for a DOOR_OPEN<->IDLE change.
REQ-023 Latency from a press to motion SHALL be 2 cycles (pedidos set at t+1, MOVE state at t+2); one floor of travel SHALL take exactly TRAVEL_CYCLES cycles.

Reset
REQ-024 When iRST_N=0 at a rising edge, the FSM SHALL go to IDLE with andar_atual=0, pedidos=0, estado_atual=0, lcd_refresh=0, porta_aberta=0, dir=up and counter=0.
REQ-025 Reset SHALL take effect from any state, including mid-travel and door-open, with no partial floor step.

Verification (TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-026 Scenario 1: hold iRST_N=0 for 2 cycles from random state -> all outputs 0, andar_atual=0.
REQ-027 Scenario 2: idle at floor 0, chamada=1000 for 1 cycle at t0 -> pedidos=1000 at t0+1; estado_atual=1 with lcd_refresh=1 at t0+2; andar_atual=1,2,3 at t0+6, t0+10 and t0+14; at t0+14 porta_aberta=1, estado_atual=0, lcd_refresh=1, pedidos=0; IDLE at t0+17.
REQ-028 Scenario 3: moving up from floor 1 toward 3, pulse chamada=0101 -> stops at 2 with the door open, continues to 3, then reverses with estado_atual=2 plus a refresh pulse, and ends at floor 0 with pedidos=0.
REQ-029 Scenario 4: door open at floor 2, press chamada=0100 on the 2nd door cycle -> door stays open 3 more cycles and pedidos[2] stays 0.
REQ-030 Scenario 5: idle at floor 0, press chamada=0001 -> DOOR_OPEN for 3 cycles with no lcd_refresh pulse and andar_atual unchanged.
REQ-031 Scenario 6: iRST_N=0 for one cycle while in MOVE_DOWN mid-count -> next cycle IDLE, andar_atual=0, pedidos=0, and no lcd_refresh pulse.

Source files
------------

// File: rtl/lift_controller.sv
// Four-floor lift controller: request latching, up/down travel timing, door dwell and
// LCD state-change signalling.
module lift_controller #(
    parameter int unsigned TRAVEL_CYCLES = 50_000_000,
    parameter int unsigned DOOR_CYCLES   = 100_000_000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [3:0] chamada,
    output logic [1:0] estado_atual,
    output logic       lcd_refresh,
    output logic [1:0] andar_atual,
    output logic [3:0] pedidos,
    output logic       porta_aberta
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StMoveUp   = 2'd1,
        StMoveDown = 2'd2,
        StDoorOpen = 2'd3
    } state_t;

    localparam logic [26:0] TravelLast = 27'(TRAVEL_CYCLES - 1);
    localparam logic [26:0] DoorLast   = 27'(DOOR_CYCLES - 1);

    state_t      r_state;
    logic [1:0]  r_floor;
    logic [3:0]  r_pedidos;
    logic        r_dir;      // 1 = up, 0 = down
    logic [26:0] r_cnt;
    logic        r_lcd;

    state_t      w_next;
    logic [1:0]  w_floor_next;
    logic        w_dir_next;
    logic [26:0] w_cnt_next;
    logic [3:0]  w_clear;
    logic [3:0]  w_here;
    logic [3:0]  w_above;
    logic [3:0]  w_below;

    function automatic logic [1:0] estado_of(input state_t s);
        unique case (s)
            StMoveUp:   return 2'd1;
            StMoveDown: return 2'd2;
            default:    return 2'd0;
        endcase
    endfunction

    always_comb begin
        w_here       = 4'b0001 << r_floor;
        w_above      = r_pedidos & (4'b1110 << r_floor);
        w_below      = r_pedidos & (4'b0111 >> (2'd3 - r_floor));
        w_next       = r_state;
        w_floor_next = r_floor;
        w_dir_next   = r_dir;
        w_cnt_next   = r_cnt + 27'd1;
        w_clear      = 4'b0000;

        unique case (r_state)
            StIdle: begin
                w_cnt_next = 27'd0;
                if (|(r_pedidos & w_here)) begin
                    w_next  = StDoorOpen;
                    w_clear = w_here;
                end else if (|w_above) begin
                    w_next     = StMoveUp;
                    w_dir_next = 1'b1;
                end else if (|w_below) begin
                    w_next     = StMoveDown;
                    w_dir_next = 1'b0;
                end
            end
            StMoveUp: begin
                // No target left above: stop instead of stepping past floor 3.
                if (!(|w_above)) begin
                    w_next = StIdle;
                end else if (r_cnt == TravelLast) begin
                    w_floor_next = r_floor + 2'd1;
                    w_cnt_next   = 27'd0;
                    if (|(r_pedidos & (w_here << 1))) begin
                        w_next  = StDoorOpen;
                        w_clear = w_here << 1;
                    end
                end
            end
            StMoveDown: begin
                if (!(|w_below)) begin
                    w_next = StIdle;
                end else if (r_cnt == TravelLast) begin
                    w_floor_next = r_floor - 2'd1;
                    w_cnt_next   = 27'd0;
                    if (|(r_pedidos & (w_here >> 1))) begin
                        w_next  = StDoorOpen;
                        w_clear = w_here >> 1;
                    end
                end
            end
            StDoorOpen: begin
                // A press on the open floor extends the dwell instead of being queued.
                w_clear = w_here;
                if (|(chamada & w_here)) begin
                    w_cnt_next = 27'd0;
                end else if (r_cnt == DoorLast) begin
                    if (r_dir ? (|w_above) : (|w_below)) begin
                        w_next = r_dir ? StMoveUp : StMoveDown;
                    end else if (r_dir ? (|w_below) : (|w_above)) begin
                        w_next     = r_dir ? StMoveDown : StMoveUp;
                        w_dir_next = ~r_dir;
                    end else begin
                        w_next = StIdle;
                    end
                end
            end
            default: w_next = StIdle;
        endcase

        if (w_next != r_state) begin
            w_cnt_next = 27'd0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state   <= StIdle;
            r_floor   <= 2'd0;
            r_pedidos <= 4'b0000;
            r_dir     <= 1'b1;
            r_cnt     <= 27'd0;
            r_lcd     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_floor   <= w_floor_next;
            r_pedidos <= (r_pedidos | chamada) & ~w_clear;
            r_dir     <= w_dir_next;
            r_cnt     <= w_cnt_next;
            r_lcd     <= (estado_of(w_next) != estado_of(r_state));
        end
    end

    assign estado_atual = estado_of(r_state);
    assign lcd_refresh  = r_lcd;
    assign andar_atual  = r_floor;
    assign pedidos      = r_pedidos;
    assign porta_aberta = (r_state == StDoorOpen);

endmodule

// File: tb/tb_lift_controller.sv
// Directed bench for lift_controller with short travel/door timings: a vector table plus
// hand-written multi-floor and reset sequences.
module tb_lift_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] chamada = 4'b0000;
    logic [1:0] estado_atual;
    logic       lcd_refresh;
    logic [1:0] andar_atual;
    logic [3:0] pedidos;
    logic       porta_aberta;

    int n_checks = 0;
    int n_fail   = 0;

    lift_controller #(
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES  (3)
    ) dut (
        .iCLK        (clk),
        .iRST_N      (rst_n),
        .chamada     (chamada),
        .estado_atual(estado_atual),
        .lcd_refresh (lcd_refresh),
        .andar_atual (andar_atual),
        .pedidos     (pedidos),
        .porta_aberta(porta_aberta)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] ch;
        int         n;     // edges this row is applied for, same expectation after each
        logic [1:0] est;
        logic       lcd;
        logic [1:0] fl;
        logic [3:0] ped;
        logic       door;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t row(input logic r, input logic [3:0] ch, input int n,
                                 input logic [1:0] est, input logic lcd, input logic [1:0] fl,
                                 input logic [3:0] ped, input logic door);
        vec_t v;
        v.rst_n = r; v.ch = ch; v.n = n;
        v.est = est; v.lcd = lcd; v.fl = fl; v.ped = ped; v.door = door;
        return v;
    endfunction

    task automatic step(input logic r, input logic [3:0] ch);
        rst_n   = r;
        chamada = ch;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] est, input logic lcd,
                              input logic [1:0] fl, input logic [3:0] ped, input logic door);
        chk({tag, ".estado_atual"}, {6'd0, estado_atual}, {6'd0, est});
        chk({tag, ".lcd_refresh"},  {7'd0, lcd_refresh},  {7'd0, lcd});
        chk({tag, ".andar_atual"},  {6'd0, andar_atual},  {6'd0, fl});
        chk({tag, ".pedidos"},      {4'd0, pedidos},      {4'd0, ped});
        chk({tag, ".porta_aberta"}, {7'd0, porta_aberta}, {7'd0, door});
    endtask

    initial begin
        // Reset, then a call to floor 3 from floor 0.
        vecs.push_back(row(0, 4'b0000, 2, 2'd0, 0, 2'd0, 4'b0000, 0));
        vecs.push_back(row(1, 4'b1000, 1, 2'd0, 0, 2'd0, 4'b1000, 0));
        vecs.push_back(row(1, 4'b0000, 1, 2'd1, 1, 2'd0, 4'b1000, 0));
        vecs.push_back(row(1, 4'b0000, 3, 2'd1, 0, 2'd0, 4'b1000, 0));
        vecs.push_back(row(1, 4'b0000, 4, 2'd1, 0, 2'd1, 4'b1000, 0));
        vecs.push_back(row(1, 4'b0000, 4, 2'd1, 0, 2'd2, 4'b1000, 0));
        vecs.push_back(row(1, 4'b0000, 1, 2'd0, 1, 2'd3, 4'b0000, 1));
        vecs.push_back(row(1, 4'b0000, 2, 2'd0, 0, 2'd3, 4'b0000, 1));
        vecs.push_back(row(1, 4'b0000, 2, 2'd0, 0, 2'd3, 4'b0000, 0));
        // Call on the current floor while idle at the top: door only, no refresh.
        vecs.push_back(row(1, 4'b1000, 1, 2'd0, 0, 2'd3, 4'b1000, 0));
        vecs.push_back(row(1, 4'b0000, 3, 2'd0, 0, 2'd3, 4'b0000, 1));
        vecs.push_back(row(1, 4'b0000, 1, 2'd0, 0, 2'd3, 4'b0000, 0));
        // Down one floor, then re-press floor 2 on the 2nd door cycle.
        vecs.push_back(row(1, 4'b0100, 1, 2'd0, 0, 2'd3, 4'b0100, 0));
        vecs.push_back(row(1, 4'b0000, 1, 2'd2, 1, 2'd3, 4'b0100, 0));
        vecs.push_back(row(1, 4'b0000, 3, 2'd2, 0, 2'd3, 4'b0100, 0));
        vecs.push_back(row(1, 4'b0000, 1, 2'd0, 1, 2'd2, 4'b0000, 1));
        vecs.push_back(row(1, 4'b0000, 1, 2'd0, 0, 2'd2, 4'b0000, 1));
        vecs.push_back(row(1, 4'b0100, 1, 2'd0, 0, 2'd2, 4'b0000, 1));
        vecs.push_back(row(1, 4'b0000, 2, 2'd0, 0, 2'd2, 4'b0000, 1));
        vecs.push_back(row(1, 4'b0000, 1, 2'd0, 0, 2'd2, 4'b0000, 0));
        // Reset from floor 2, then a call on floor 0 while idle there.
        vecs.push_back(row(0, 4'b0000, 1, 2'd0, 0, 2'd0, 4'b0000, 0));
        vecs.push_back(row(1, 4'b0001, 1, 2'd0, 0, 2'd0, 4'b0001, 0));
        vecs.push_back(row(1, 4'b0000, 3, 2'd0, 0, 2'd0, 4'b0000, 1));
        vecs.push_back(row(1, 4'b0000, 1, 2'd0, 0, 2'd0, 4'b0000, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                step(vecs[i].rst_n, vecs[i].ch);
                expect_out($sformatf("vec%0d.%0d", i, k), vecs[i].est, vecs[i].lcd,
                           vecs[i].fl, vecs[i].ped, vecs[i].door);
            end
        end

        // Stop at 2 on the way up, finish at 3, reverse and serve 0.
        step(0, 4'b0000);
        step(1, 4'b1000);
        repeat (5) step(1, 4'b0000);
        expect_out("sweep.fl1", 2'd1, 0, 2'd1, 4'b1000, 0);
        step(1, 4'b0101);
        expect_out("sweep.latch", 2'd1, 0, 2'd1, 4'b1101, 0);
        repeat (3) step(1, 4'b0000);
        expect_out("sweep.stop2", 2'd0, 1, 2'd2, 4'b1001, 1);
        repeat (3) step(1, 4'b0000);
        expect_out("sweep.resume", 2'd1, 1, 2'd2, 4'b1001, 0);
        repeat (4) step(1, 4'b0000);
        expect_out("sweep.stop3", 2'd0, 1, 2'd3, 4'b0001, 1);
        repeat (3) step(1, 4'b0000);
        expect_out("sweep.reverse", 2'd2, 1, 2'd3, 4'b0001, 0);
        repeat (12) step(1, 4'b0000);
        expect_out("sweep.stop0", 2'd0, 1, 2'd0, 4'b0000, 1);
        repeat (3) step(1, 4'b0000);
        expect_out("sweep.idle", 2'd0, 0, 2'd0, 4'b0000, 0);

        // Reset mid-count while travelling down.
        step(1, 4'b0100);
        step(1, 4'b0000);
        expect_out("rstmv.up", 2'd1, 1, 2'd0, 4'b0100, 0);
        repeat (8) step(1, 4'b0000);
        expect_out("rstmv.door2", 2'd0, 1, 2'd2, 4'b0000, 1);
        repeat (3) step(1, 4'b0000);
        step(1, 4'b0001);
        expect_out("rstmv.req", 2'd0, 0, 2'd2, 4'b0001, 0);
        step(1, 4'b0000);
        expect_out("rstmv.down", 2'd2, 1, 2'd2, 4'b0001, 0);
        repeat (2) step(1, 4'b0000);
        expect_out("rstmv.mid", 2'd2, 0, 2'd2, 4'b0001, 0);
        step(0, 4'b0000);
        expect_out("rstmv.reset", 2'd0, 0, 2'd0, 4'b0000, 0);
        step(1, 4'b0000);
        expect_out("rstmv.after", 2'd0, 0, 2'd0, 4'b0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
